mskaes_128bits_host_if: RTL and testbench
=========================================

Name: mskaes_128bits_host_if

Overview:
- Host-side initiator for the masked round-based AES-128 encryption core; drives the core's valid_in/ready/cipher_valid handshake from the opposite end.
- Takes unmasked plaintext/key from a valid/ready stream and splits each into d Boolean shares using fresh randomness.
- Launches one encryption, captures the single-cycle shared ciphertext, and recombines it onto an output valid/ready stream.
- Sbox randomness buses are not handled here; they are wired from the PRNG directly to the core.

Parameters:
- d, 2, number of shares; must be >= 2 (elaboration error otherwise).
- CNT_W, 8, width of the busy-cycle counter.
- WDOG_CYCLES, 200, watchdog limit in cycles; used only with HOSTIF_WATCHDOG_EN.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  host request valid.
- in_ready  out  1  adapter can accept a request.
- in_plaintext  in  128  unmasked plaintext.
- in_key  in  128  unmasked key.
- mask_rnd  in  256*(d-1)  fresh randomness; low 128*(d-1) bits mask the plaintext, high 128*(d-1) bits mask the key.
- core_valid_in  out  1  to core valid_in.
- core_ready  in  1  from core ready.
- core_cipher_valid  in  1  from core cipher_valid; single-cycle pulse.
- core_sh_plaintext  out  128*d  to core sh_plaintext.
- core_sh_key  out  128*d  to core sh_key.
- core_sh_ciphertext  in  128*d  from core sh_ciphertext; valid only during the cipher_valid cycle.
- out_valid  out  1  result valid.
- out_ready  in  1  host accepts the result.
- out_ciphertext  out  128  unmasked ciphertext.
- busy_cycles  out  CNT_W  cycles from launch to cipher_valid for the last job.

Behaviour:
- Share layout: share i of bit j sits at index j*d+i.
- Sharing: share i (i >= 1) = r_i, taken from mask_rnd bits [(i-1)*128 +: 128] of the relevant half. Share 0 = x ^ r_1 ^ ... ^ r_(d-1).
- Recombine: out bit j = XOR over i of sh[j*d+i].
- FSM states: IDLE, LOAD, BUSY, HOLD. Reset state is IDLE.
- Reset values: in_ready=0 during reset, then 1 in IDLE. core_valid_in=0, core_sh_* all zero, out_valid=0, out_ciphertext=0, busy_cycles=0.
- IDLE:
  - in_ready=1.
  - On in_valid: register the shared plaintext/key from the current mask_rnd, then go to LOAD.
  - mask_rnd is sampled only in this cycle.
- LOAD:
  - core_valid_in=1; core_sh_* held stable.
  - In a cycle with core_ready=1 the core fetches: clear core_sh_* to zero on the next edge, clear the counter, go to BUSY.
  - If core_ready=0, stay in LOAD indefinitely.
- BUSY:
  - core_valid_in=0; counter increments each cycle and saturates at all-ones.
  - On core_cipher_valid=1: capture the recombined core_sh_ciphertext into out_ciphertext in that same cycle, copy counter+1 to busy_cycles, go to HOLD.
- HOLD:
  - out_valid=1; out_ciphertext stable.
  - On out_ready: on the next edge set out_valid=0, zero out_ciphertext, go to IDLE.
  - No new request is accepted until then (in_ready=0), so only one job is ever in flight.
- core_cipher_valid in IDLE, LOAD or HOLD: ignored; no state change.
- in_valid outside IDLE: ignored (in_ready=0).
- nrst asserted mid-operation: everything returns to reset values at once, and the share registers are zeroed. The core has its own reset; the integrator resets both together.
- Shares are never recombined anywhere except the output capture.

Optional Feature:
- Macro HOSTIF_WATCHDOG_EN.
- Defined:
  - Adds output wdog_err (1 bit, reset 0).
  - If BUSY lasts WDOG_CYCLES cycles without core_cipher_valid: pulse wdog_err for one cycle, zero all share registers, go to IDLE.
  - out_valid stays 0 for that job.
- Not defined: no wdog_err port; BUSY waits indefinitely.

Decomposition:
- Shared package (mskaes_host_pkg):
  - FSM state enum (2-bit encoding: IDLE=0, LOAD=1, BUSY=2, HOLD=3).
  - Constant AES_BLK=128.
  - FIPS-197 test vector constants, for the bench.
- One sub-module: mskaes_share_codec, a purely combinational split(x, r) and recombine(sh) parameterised by d and width. It is instantiated twice for plaintext/key splitting and once for ciphertext recombination.

Test Plan:
- FIPS-197 C.1 with the real core, d=2, random mask_rnd: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid held until out_ready.
- Same vector run with mask_rnd all-zero, then all-ones, and with d=3 -> identical ciphertext each time. core_sh_plaintext for mask all-ones equals ~pt on share 0 and all-ones on share 1.
- Core model holding core_ready=0 for 5 cycles -> core_valid_in high for 6 cycles, shares stable, then zero after the fetch.
- out_ready held low 20 cycles, with in_valid high and a spurious core_cipher_valid pulse -> in_ready=0, out_ciphertext unchanged. Back-to-back jobs produce no overlap.
- nrst asserted in BUSY, then released -> all outputs zero, IDLE, in_ready=1. The next job completes correctly.
- HOSTIF_WATCHDOG_EN with a core model that never pulses -> wdog_err pulses exactly WDOG_CYCLES cycles after the fetch, out_valid stays 0, FSM returns to IDLE.

Source files
------------

// File: rtl/mskaes_host_pkg.sv
// Shared types and constants for the masked AES-128 host adapter.
// Holds the FSM encoding, the block width and the FIPS-197 C.1 reference vector.
package mskaes_host_pkg;

  localparam int AES_BLK = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_BUSY = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam logic [AES_BLK-1:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [AES_BLK-1:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [AES_BLK-1:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

endpackage

// File: rtl/mskaes_share_codec.sv
// Combinational Boolean masking codec: SPLIT=1 turns {r_(d-1)..r_1, x} into d shares,
// SPLIT=0 XORs d shares back into one word. Share i of bit j sits at index j*d+i.
module mskaes_share_codec #(
  parameter int d     = 2,
  parameter int W     = 128,
  parameter bit SPLIT = 1'b1,
  localparam int OUT_W = SPLIT ? W * d : W
) (
  input  logic [W*d-1:0]   din,
  output logic [OUT_W-1:0] dout
);

  if (SPLIT) begin : g_split
    always_comb begin
      logic acc;
      // NOTE: every variable gets a default before the loops so no path leaves it unassigned (no latch).
      acc  = 1'b0;
      dout = '0;
      for (int j = 0; j < W; j++) begin
        acc = din[j];
        for (int i = 1; i < d; i++) begin
          acc            ^= din[i*W + j];
          dout[j*d + i]   = din[i*W + j];
        end
        dout[j*d] = acc;
      end
    end
  end else begin : g_recombine
    always_comb begin
      dout = '0;
      for (int j = 0; j < W; j++) begin
        dout[j] = ^din[j*d +: d];
      end
    end
  end

endmodule

// File: rtl/mskaes_128bits_host_if.sv
// Host-side initiator for the masked AES-128 core: masks requests, launches one job, unmasks the result.
// Optional HOSTIF_WATCHDOG_EN adds wdog_err and aborts a job that stays in BUSY for WDOG_CYCLES cycles.
module mskaes_128bits_host_if
  import mskaes_host_pkg::*;
#(
  parameter int d           = 2,
  parameter int CNT_W       = 8,
  parameter int WDOG_CYCLES = 200
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AES_BLK-1:0]         in_plaintext,
  input  logic [AES_BLK-1:0]         in_key,
  input  logic [2*AES_BLK*(d-1)-1:0] mask_rnd,
  output logic                       core_valid_in,
  input  logic                       core_ready,
  input  logic                       core_cipher_valid,
  output logic [AES_BLK*d-1:0]       core_sh_plaintext,
  output logic [AES_BLK*d-1:0]       core_sh_key,
  input  logic [AES_BLK*d-1:0]       core_sh_ciphertext,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [AES_BLK-1:0]         out_ciphertext,
`ifdef HOSTIF_WATCHDOG_EN
  output logic                       wdog_err,
`endif
  output logic [CNT_W-1:0]           busy_cycles
);

  localparam int RW = AES_BLK * (d - 1);

  if (d < 2) begin : g_bad_d
    $error("mskaes_128bits_host_if: d must be >= 2");
  end
  if (WDOG_CYCLES < 1 || WDOG_CYCLES > (1 << CNT_W)) begin : g_bad_wdog
    $error("mskaes_128bits_host_if: WDOG_CYCLES must be in 1..2**CNT_W");
  end

  logic [AES_BLK*d-1:0] pt_split;
  logic [AES_BLK*d-1:0] key_split;
  logic [AES_BLK-1:0]   ct_rec;
  logic [CNT_W-1:0]     cnt;
  state_e               state;

  mskaes_share_codec #(.d(d), .W(AES_BLK), .SPLIT(1'b1)) u_split_pt (
    .din  ({mask_rnd[RW-1:0], in_plaintext}),
    .dout (pt_split)
  );

  mskaes_share_codec #(.d(d), .W(AES_BLK), .SPLIT(1'b1)) u_split_key (
    .din  ({mask_rnd[2*RW-1:RW], in_key}),
    .dout (key_split)
  );

  // The only place shares are ever recombined.
  mskaes_share_codec #(.d(d), .W(AES_BLK), .SPLIT(1'b0)) u_recombine (
    .din  (core_sh_ciphertext),
    .dout (ct_rec)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // NOTE: share registers are reset and cleared after each fetch so masked data never lingers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state             <= ST_IDLE;
      in_ready          <= 1'b0;
      core_valid_in     <= 1'b0;
      core_sh_plaintext <= '0;
      core_sh_key       <= '0;
      out_valid         <= 1'b0;
      out_ciphertext    <= '0;
      busy_cycles       <= '0;
      cnt               <= '0;
`ifdef HOSTIF_WATCHDOG_EN
      wdog_err          <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register update tied to the same clock edge.
`ifdef HOSTIF_WATCHDOG_EN
      wdog_err <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            core_sh_plaintext <= pt_split;
            core_sh_key       <= key_split;
            core_valid_in     <= 1'b1;
            in_ready          <= 1'b0;
            state             <= ST_LOAD;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (core_ready) begin
            core_sh_plaintext <= '0;
            core_sh_key       <= '0;
            core_valid_in     <= 1'b0;
            cnt               <= '0;
            state             <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (core_cipher_valid) begin
            out_ciphertext <= ct_rec;
            out_valid      <= 1'b1;
            busy_cycles    <= sat_inc(cnt);
            state          <= ST_HOLD;
          end
`ifdef HOSTIF_WATCHDOG_EN
          else if (cnt == CNT_W'(WDOG_CYCLES - 1)) begin
            wdog_err          <= 1'b1;
            core_sh_plaintext <= '0;
            core_sh_key       <= '0;
            in_ready          <= 1'b1;
            state             <= ST_IDLE;
          end
`endif
          else begin
            cnt <= sat_inc(cnt);
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid      <= 1'b0;
            out_ciphertext <= '0;
            in_ready       <= 1'b1;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mskaes_128bits_host_if.sv
// Directed bench for mskaes_128bits_host_if with a behavioural core model (d=2 and d=3 instances).
// Compile with +define+HOSTIF_WATCHDOG_EN to also exercise the watchdog.
module tb_mskaes_128bits_host_if;
  import mskaes_host_pkg::*;

  localparam int WDOG = 200;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, core_valid_in, core_ready, core_cipher_valid;
  logic         out_valid, out_ready;
  logic [127:0] in_plaintext, in_key, out_ciphertext;
  logic [255:0] mask_rnd, core_sh_plaintext, core_sh_key, core_sh_ciphertext;
  logic [7:0]   busy_cycles;

  logic         in_valid_3, in_ready_3, core_valid_in_3, core_ready_3, core_cipher_valid_3;
  logic         out_valid_3, out_ready_3;
  logic [127:0] out_ciphertext_3;
  logic [511:0] mask_rnd_3;
  logic [383:0] core_sh_plaintext_3, core_sh_key_3, core_sh_ciphertext_3;
  logic [7:0]   busy_cycles_3;
`ifdef HOSTIF_WATCHDOG_EN
  logic         wdog_err, wdog_err_3;
`endif

  mskaes_128bits_host_if #(.d(2), .CNT_W(8), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
    .in_plaintext(in_plaintext), .in_key(in_key), .mask_rnd(mask_rnd),
    .core_valid_in(core_valid_in), .core_ready(core_ready), .core_cipher_valid(core_cipher_valid),
    .core_sh_plaintext(core_sh_plaintext), .core_sh_key(core_sh_key),
    .core_sh_ciphertext(core_sh_ciphertext), .out_valid(out_valid), .out_ready(out_ready),
    .out_ciphertext(out_ciphertext),
`ifdef HOSTIF_WATCHDOG_EN
    .wdog_err(wdog_err),
`endif
    .busy_cycles(busy_cycles)
  );

  mskaes_128bits_host_if #(.d(3), .CNT_W(8), .WDOG_CYCLES(WDOG)) dut3 (
    .clk(clk), .nrst(nrst), .in_valid(in_valid_3), .in_ready(in_ready_3),
    .in_plaintext(FIPS_PT), .in_key(FIPS_KEY), .mask_rnd(mask_rnd_3),
    .core_valid_in(core_valid_in_3), .core_ready(core_ready_3),
    .core_cipher_valid(core_cipher_valid_3),
    .core_sh_plaintext(core_sh_plaintext_3), .core_sh_key(core_sh_key_3),
    .core_sh_ciphertext(core_sh_ciphertext_3), .out_valid(out_valid_3), .out_ready(out_ready_3),
    .out_ciphertext(out_ciphertext_3),
`ifdef HOSTIF_WATCHDOG_EN
    .wdog_err(wdog_err_3),
`endif
    .busy_cycles(busy_cycles_3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference masking model: share i of bit j at j*nd+i.
  function automatic logic [383:0] split_model(input logic [127:0] x, input logic [255:0] r,
                                               input int nd);
    logic [383:0] sh;
    logic         s0;
    sh = '0;
    for (int j = 0; j < 128; j++) begin
      s0 = x[j];
      for (int i = 1; i < nd; i++) begin
        sh[j*nd + i] = r[(i-1)*128 + j];
        s0 = s0 ^ r[(i-1)*128 + j];
      end
      sh[j*nd] = s0;
    end
    return sh;
  endfunction

  function automatic logic [127:0] recomb_model(input logic [383:0] sh, input int nd);
    logic [127:0] y;
    y = '0;
    for (int j = 0; j < 128; j++)
      for (int i = 0; i < nd; i++) y[j] = y[j] ^ sh[j*nd + i];
    return y;
  endfunction

  function automatic logic [127:0] get_share(input logic [383:0] sh, input int i, input int nd);
    logic [127:0] s;
    for (int j = 0; j < 128; j++) s[j] = sh[j*nd + i];
    return s;
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
    logic [255:0] mask;
    int           ready_delay;
    int           latency;
    int           hold;
    bit           spurious;
  } vec_t;

  vec_t vecs[5];

  task automatic run_job(input vec_t v, input int idx);
    logic [255:0] snap_pt, snap_key, tmp;
    int           hi, k;
    bit           stable;
    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin step(); k++; end
    check($sformatf("v%0d in_ready idle", idx), in_ready, 1);
    in_valid = 1'b1; in_plaintext = v.pt; in_key = v.key; mask_rnd = v.mask;
    step();
    in_valid = 1'b0; in_plaintext = ~v.pt; in_key = ~v.key; mask_rnd = ~v.mask;
    check($sformatf("v%0d load valid_in", idx), core_valid_in, 1);
    check($sformatf("v%0d load in_ready", idx), in_ready, 0);
    check($sformatf("v%0d pt sh0", idx), get_share(core_sh_plaintext, 0, 2), v.pt ^ v.mask[127:0]);
    check($sformatf("v%0d pt sh1", idx), get_share(core_sh_plaintext, 1, 2), v.mask[127:0]);
    check($sformatf("v%0d key sh0", idx), get_share(core_sh_key, 0, 2), v.key ^ v.mask[255:128]);
    check($sformatf("v%0d key sh1", idx), get_share(core_sh_key, 1, 2), v.mask[255:128]);
    snap_pt = core_sh_plaintext; snap_key = core_sh_key;
    hi = 0; stable = 1'b1; core_ready = 1'b0;
    for (int c = 0; c < v.ready_delay; c++) begin
      hi += int'(core_valid_in);
      if (core_sh_plaintext !== snap_pt || core_sh_key !== snap_key) stable = 1'b0;
      step();
    end
    core_ready = 1'b1;
    hi += int'(core_valid_in);
    if (core_sh_plaintext !== snap_pt || core_sh_key !== snap_key) stable = 1'b0;
    step();
    core_ready = 1'b0;
    check($sformatf("v%0d valid_in cycles", idx), hi, v.ready_delay + 1);
    check($sformatf("v%0d shares stable", idx), stable, 1);
    check($sformatf("v%0d fetched valid_in", idx), core_valid_in, 0);
    check($sformatf("v%0d shares cleared", idx), {core_sh_plaintext, core_sh_key}, 0);
    for (int c = 0; c < v.latency - 1; c++) step();
    tmp = split_model(v.ct, rnd256(), 2);
    core_cipher_valid = 1'b1; core_sh_ciphertext = tmp;
    step();
    core_cipher_valid = 1'b0; core_sh_ciphertext = rnd256();
    check($sformatf("v%0d out_valid", idx), out_valid, 1);
    check($sformatf("v%0d out_ct", idx), out_ciphertext, v.ct);
    check($sformatf("v%0d busy_cycles", idx), busy_cycles, (v.latency > 255) ? 255 : v.latency);
    stable = 1'b1;
    for (int c = 0; c < v.hold; c++) begin
      in_valid = v.spurious;
      core_cipher_valid = v.spurious && (c == 3);
      core_sh_ciphertext = rnd256();
      step();
      if (out_valid !== 1'b1 || out_ciphertext !== v.ct || in_ready !== 1'b0 ||
          busy_cycles !== 8'((v.latency > 255) ? 255 : v.latency)) stable = 1'b0;
    end
    in_valid = 1'b0; core_cipher_valid = 1'b0;
    check($sformatf("v%0d hold stable", idx), stable, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check($sformatf("v%0d released out_valid", idx), out_valid, 0);
    check($sformatf("v%0d released out_ct", idx), out_ciphertext, 0);
    check($sformatf("v%0d back in idle", idx), in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [383:0] tmp3;
    int           n;
    in_valid = 0; in_plaintext = '0; in_key = '0; mask_rnd = '0;
    core_ready = 0; core_cipher_valid = 0; core_sh_ciphertext = '0; out_ready = 0;
    in_valid_3 = 0; mask_rnd_3 = '0; core_ready_3 = 0; core_cipher_valid_3 = 0;
    core_sh_ciphertext_3 = '0; out_ready_3 = 0;

    vecs[0] = '{FIPS_PT, FIPS_KEY, FIPS_CT, rnd256(), 0, 10, 2, 1'b0};
    vecs[1] = '{FIPS_PT, FIPS_KEY, FIPS_CT, '0, 0, 3, 0, 1'b0};
    vecs[2] = '{FIPS_PT, FIPS_KEY, FIPS_CT, '1, 5, 1, 1, 1'b0};
    vecs[3] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, rnd256(), 2, 7, 20, 1'b1};
`ifdef HOSTIF_WATCHDOG_EN
    vecs[4] = '{FIPS_PT, FIPS_KEY, FIPS_CT, rnd256(), 1, 150, 0, 1'b0};
`else
    vecs[4] = '{FIPS_PT, FIPS_KEY, FIPS_CT, rnd256(), 1, 300, 0, 1'b0};
`endif

    step(); step();
    check("reset in_ready", in_ready, 0);
    check("reset outputs", {core_valid_in, out_valid, out_ciphertext, busy_cycles}, 0);
    check("reset shares", {core_sh_plaintext, core_sh_key}, 0);
    nrst = 1'b1;
    step();
    check("post-reset in_ready", in_ready, 1);

    for (int v = 0; v < 5; v++) run_job(vecs[v], v);

    // Reset while BUSY.
    in_valid = 1'b1; in_plaintext = FIPS_PT; in_key = FIPS_KEY; mask_rnd = rnd256();
    step();
    in_valid = 1'b0; core_ready = 1'b1;
    step();
    core_ready = 1'b0;
    step(); step();
    #2 nrst = 1'b0;
    #1;
    check("midreset in_ready", in_ready, 0);
    check("midreset outputs", {core_valid_in, out_valid, out_ciphertext, busy_cycles}, 0);
    check("midreset shares", {core_sh_plaintext, core_sh_key}, 0);
    step();
    nrst = 1'b1;
    step();
    check("after reset in_ready", in_ready, 1);
    check("after reset out_valid", out_valid, 0);
    vecs[0].mask = rnd256();
    run_job(vecs[0], 10);

    // d=3 instance: same vector, three shares.
    mask_rnd_3 = {rnd256(), rnd256()};
    in_valid_3 = 1'b1;
    step();
    in_valid_3 = 1'b0;
    check("d3 valid_in", core_valid_in_3, 1);
    check("d3 pt recombine", recomb_model(core_sh_plaintext_3, 3), FIPS_PT);
    check("d3 key recombine", recomb_model(core_sh_key_3, 3), FIPS_KEY);
    check("d3 pt sh2", get_share(core_sh_plaintext_3, 2, 3), mask_rnd_3[255:128]);
    check("d3 key sh1", get_share(core_sh_key_3, 1, 3), mask_rnd_3[383:256]);
    core_ready_3 = 1'b1;
    step();
    core_ready_3 = 1'b0;
    check("d3 fetched", {core_valid_in_3, core_sh_plaintext_3, core_sh_key_3}, 0);
    step(); step();
    tmp3 = split_model(FIPS_CT, rnd256(), 3);
    core_cipher_valid_3 = 1'b1; core_sh_ciphertext_3 = tmp3;
    step();
    core_cipher_valid_3 = 1'b0; core_sh_ciphertext_3 = '0;
    check("d3 out_valid", out_valid_3, 1);
    check("d3 out_ct", out_ciphertext_3, FIPS_CT);
    check("d3 busy_cycles", busy_cycles_3, 3);
    out_ready_3 = 1'b1;
    step();
    out_ready_3 = 1'b0;
    check("d3 released", {out_valid_3, out_ciphertext_3}, 0);

`ifdef HOSTIF_WATCHDOG_EN
    in_valid = 1'b1; in_plaintext = FIPS_PT; in_key = FIPS_KEY; mask_rnd = rnd256();
    step();
    in_valid = 1'b0; core_ready = 1'b1;
    step();
    core_ready = 1'b0;
    n = 0;
    while (wdog_err !== 1'b1 && n < WDOG + 50) begin step(); n++; end
    check("wdog delay", n, WDOG);
    check("wdog out_valid", out_valid, 0);
    check("wdog in_ready", in_ready, 1);
    check("wdog shares", {core_sh_plaintext, core_sh_key}, 0);
    step();
    check("wdog pulse width", wdog_err, 0);
`else
    n = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
